// File: rtl/mul4_seq.sv
// mul4_seq: 4x4 unsigned sequential shift-add multiplier.
// The add of each step is done by an external 4-bit ALU; this block drives
// the ALU operands/opcode and consumes its combinational result/carry.
//
// Handshake: start is a request sampled only while IDLE (busy=0). When the
// rising edge sees start=1 in IDLE, a and b are captured and busy rises.
// Requests while busy are dropped, not queued. done pulses high for exactly
// one cycle with product already valid; product then holds until the next
// completion (or reset).
module mul4_seq #(
  parameter logic [1:0] OP_ADD = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [3:0] mq_q,    mq_d;
  logic [3:0] acc_q,   acc_d;
  logic [1:0] cnt_q,   cnt_d;
  logic [7:0] product_q, product_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= 4'h0;
      mq_q      <= 4'h0;
      acc_q     <= 4'h0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ALU drive: only CALC issues a real add, otherwise operands are parked at zero.
  always_comb begin
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    alu_op = OP_ADD;
    if (state_q == CALC) begin
      alu_a = acc_q;
      alu_b = mq_q[0] ? mcand_q : 4'h0;
    end
  end

  // Next-state and datapath update: capture in IDLE, shift-add in CALC.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = 4'h0;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        // {carry, sum, mq} is a 9-bit value shifted right by one each step;
        // the sum LSB drops into mq as the next finished product bit.
        acc_d = {alu_cout, alu_res[3:1]};
        mq_d  = {alu_res[0], mq_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {acc_d, mq_d};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mul4_seq.md
MUL4_SEQ -- requirements
Module: mul4_seq

Interface
REQ-001 SHALL have parameter OP_ADD, default 2'b00, the ALU opcode driven for every iteration add.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse/level; sampled only in IDLE.
REQ-005 SHALL have port a  input  4  multiplicand, unsigned; sampled with start.
REQ-006 SHALL have port b  input  4  multiplier, unsigned; sampled with start.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse: product valid.
REQ-009 SHALL have port product  output  8  unsigned a*b, registered.
REQ-010 SHALL have port alu_a  output  4  operand A to the external 4-bit ALU.
REQ-011 SHALL have port alu_b  output  4  operand B to the external 4-bit ALU.
REQ-012 SHALL have port alu_op  output  2  opcode to the ALU (0 ADD, 1 SUB, 2 AND, 3 OR).
REQ-013 SHALL have port alu_res  input  4  ALU combinational result, same cycle.
REQ-014 SHALL have port alu_cout  input  1  ALU carry-out for ADD, same cycle.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; encoding free.
REQ-016 IDLE: start=1 at rising edge SHALL latch mcand<=a, mq<=b, acc<=0, cnt<=0, go to CALC; else stay IDLE.
REQ-017 CALC: alu_op=OP_ADD, alu_a=acc, alu_b = mq[0] ? mcand : 4'h0 (combinational from registers).
REQ-018 CALC edge: 9-bit {alu_cout, alu_res, mq} SHALL shift right one: acc<={alu_cout, alu_res[3:1]}, mq<={alu_res[0], mq[3:1]}, cnt<=cnt+1.
REQ-019 CALC with cnt==3 at edge SHALL perform REQ-018, load product<={new acc, new mq}, go to DONE; exactly 4 CALC cycles.
REQ-020 DONE: done=1 for exactly one cycle; next edge SHALL go to IDLE unconditionally.
REQ-021 Latency: start accepted at edge E0 -> done high in the cycle after E4 -> IDLE after E5; new start accepted no earlier than E6.
REQ-022 start while busy (CALC or DONE) SHALL be ignored; no queuing, latched operands unchanged.
REQ-023 a/b changes after E0 SHALL NOT affect the running product.
REQ-024 product SHALL hold its value from DONE until the next completion; not cleared on start.
REQ-025 Outside CALC: alu_a=0, alu_b=0, alu_op=OP_ADD.
REQ-026 alu_cout SHALL be consumed only in CALC; no overflow possible (acc+mcand <= 30 fits 5 bits).
REQ-027 Result width: product = a*b exact, range 0..225, no truncation.

Reset
REQ-028 rst_n=0 SHALL immediately (no clock) force state IDLE, busy=0, done=0, product=8'h00, acc=0, mq=0, mcand=0, cnt=0.
REQ-029 rst_n asserted mid-CALC or in DONE SHALL abort; no done pulse; product=0.
REQ-030 First start SHALL be accepted at the first rising edge with rst_n=1 and start=1.

Verification
REQ-031 a=4'hF, b=4'hF, start 1 cycle -> busy 5 cycles, done once at cycle 5, product=8'hE1.
REQ-032 a=4'h9, b=4'hA -> product=8'h5A; alu_b sequence per CALC cycle 0,9,0,9.
REQ-033 a=4'h7, b=4'h0 -> product=8'h00; alu_b=0 all four CALC cycles; a=0,b=F -> 8'h00.
REQ-034 start held high continuously with a=3,b=5 -> done every 6 cycles, product=8'h0F; a changed to F during CALC leaves product 8'h0F.
REQ-035 start a=F,b=F, rst_n low during 3rd CALC cycle -> busy=0, done=0, product=8'h00 asynchronously; no done after release.
REQ-036 Self-check against reference model for all 256 (a,b) pairs -> product==a*b, done exactly once per accepted start.
